// File: rtl/pipe_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall vector, flush redirect, stall watchdog.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
   parameter int unsigned STALL_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stallreq_from_id,
   input  logic        stallreq_from_ex,
   input  logic        stallreq_from_mem,
   input  logic [31:0] excepttype_i,
   input  logic [31:0] cp0_epc_i,
   output logic [5:0]  stall,
   output logic        flush,
   output logic [31:0] new_pc,
   output logic        stall_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0] stall_cycles_o,
   output logic [15:0] flush_count_o
`endif
);

   typedef enum logic [1:0] {
      StRun       = 2'd0,
      StHold      = 2'd1,
      StFlush     = 2'd2,
      StFlushWait = 2'd3
   } state_e;

   localparam logic [15:0] LimitVal = 16'(STALL_LIMIT);

   state_e      state_q, state_d;
   logic [31:0] new_pc_q, new_pc_d;
   logic [15:0] run_cnt_q, run_cnt_d;
   logic        timeout_q, timeout_d;
   logic        except;
   logic        any_req;
   logic [31:0] vector;

   assign except  = (excepttype_i != 32'h0);
   assign any_req = stallreq_from_id | stallreq_from_ex | stallreq_from_mem;

   always_comb begin
      case (excepttype_i)
         32'h0000_0001: vector = 32'h0000_0020;
         32'h0000_0008,
         32'h0000_000a,
         32'h0000_000c,
         32'h0000_000d: vector = 32'h0000_0040;
         32'h0000_000e: vector = cp0_epc_i;
         default:       vector = 32'h0000_0040;
      endcase
   end

   // Reset gates the outputs so nothing escapes during the rst cycle.
   always_comb begin
      stall    = 6'b000000;
      flush    = 1'b0;
      state_d  = state_q;
      new_pc_d = new_pc_q;
      if (!rst) begin
         case (state_q)
            StRun, StHold: begin
               if (except) begin
                  state_d  = StFlush;
                  new_pc_d = vector;
               end else begin
                  if (stallreq_from_mem)     stall = 6'b011111;
                  else if (stallreq_from_ex) stall = 6'b001111;
                  else if (stallreq_from_id) stall = 6'b000111;
                  state_d = any_req ? StHold : StRun;
               end
            end
            StFlush: begin
               flush   = 1'b1;
               state_d = StFlushWait;
            end
            StFlushWait: state_d = StRun;
            default:     state_d = StRun;
         endcase
      end
   end

   always_comb begin
      run_cnt_d = 16'h0;
      if (stall != 6'b000000) begin
         run_cnt_d = (run_cnt_q == 16'hffff) ? run_cnt_q : run_cnt_q + 16'd1;
      end
      timeout_d = timeout_q | ((stall != 6'b000000) && (run_cnt_d == LimitVal));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StRun;
         new_pc_q  <= 32'h0;
         run_cnt_q <= 16'h0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         new_pc_q  <= new_pc_d;
         run_cnt_q <= run_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign new_pc        = new_pc_q;
   assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles_q;
   logic [15:0] flush_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'h0;
         flush_count_q  <= 16'h0;
      end else begin
         if (stall != 6'b000000) stall_cycles_q <= stall_cycles_q + 32'd1;
         if (flush)              flush_count_q  <= flush_count_q + 16'd1;
      end
   end

   assign stall_cycles_o = stall_cycles_q;
   assign flush_count_o  = flush_count_q;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STALL_LIMIT, default 255, SHALL set the consecutive-stall-cycle count at which the watchdog fires (legal range 1..65535).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_from_id  input  1  decode hazard (load-use) hold request.
REQ-005 stallreq_from_ex  input  1  multi-cycle execute op (div/madd) busy request.
REQ-006 stallreq_from_mem  input  1  data-bus wait request.
REQ-007 excepttype_i  input  32  exception code from MEM stage; 0 = none.
REQ-008 cp0_epc_i  input  32  EPC value for eret return.
REQ-009 stall  output  6  per-stage hold vector: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-010 flush  output  1  pipeline flush strobe.
REQ-011 new_pc  output  32  redirect address, valid while flush=1.
REQ-012 stall_timeout  output  1  sticky watchdog flag.

Function
REQ-013 FSM states SHALL be RUN, HOLD, FLUSH, FLUSH_WAIT, encoded in a 2-bit register.
REQ-014 Request priority SHALL be exception > mem > ex > id.
REQ-015 stall SHALL be combinational from current requests and state (zero latency): mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, none -> 6'b000000.
REQ-016 RUN -> HOLD when any stall request is high and excepttype_i is 0; HOLD -> RUN when all requests are low.
REQ-017 excepttype_i != 0 in RUN or HOLD SHALL transition to FLUSH on the next edge and capture new_pc into a register.
REQ-018 new_pc mapping SHALL be: 0x00000001 -> 0x00000020; 0x00000008, 0x0000000a, 0x0000000c, 0x0000000d -> 0x00000040; 0x0000000e -> cp0_epc_i sampled at detection; any other non-zero code -> 0x00000040.
REQ-019 In FLUSH, flush SHALL be 1 for exactly one cycle and stall SHALL be 6'b000000.
REQ-020 FLUSH SHALL always move to FLUSH_WAIT.
REQ-021 In FLUSH_WAIT, stall SHALL be 6'b000000, flush SHALL be 0, and excepttype_i SHALL be ignored; the state SHALL move to RUN on the next edge.
REQ-022 An exception that coincides with a stall request SHALL win: stall is 6'b000000 in that cycle, and the FSM enters FLUSH.
REQ-023 Outside FLUSH, flush SHALL be 0 and new_pc SHALL hold its last captured value.
REQ-024 A 16-bit run counter SHALL increment each cycle stall != 0 and clear on any cycle stall == 0; it SHALL saturate, never wrap.
REQ-025 When the run counter reaches STALL_LIMIT, stall_timeout SHALL set on that edge and stay set until rst.

Reset
REQ-026 While rst=1 at an edge: state=RUN, new_pc=0x00000000, run counter=0, stall_timeout=0; stall=6'b000000 and flush=0 during the rst cycle regardless of inputs.
REQ-027 Reset asserted in FLUSH or FLUSH_WAIT SHALL abort the flush with no flush pulse after reset release.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN defined: the block SHALL add output stall_cycles_o (32-bit), counting every cycle with stall != 0, and output flush_count_o (16-bit), counting flush pulses; both SHALL clear on rst and wrap at maximum.
REQ-029 Macro PIPE_CTRL_PERF_EN undefined: the ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 id=1 for 3 cycles -> stall=6'b000111 in those 3 cycles, then 6'b000000 the cycle id drops; flush stays 0.
REQ-031 id=1, ex=1, mem=1 together -> stall=6'b011111; drop mem -> 6'b001111; drop ex -> 6'b000111.
REQ-032 excepttype_i=0x0000000e, cp0_epc_i=0x00400104, ex=1 -> stall=0 that cycle; next cycle flush=1, new_pc=0x00400104; following cycle flush=0.
REQ-033 excepttype_i=0x00000008 held for 3 cycles -> exactly one flush pulse with new_pc=0x00000040; the FLUSH_WAIT cycle ignores the exception; a second pulse follows only after the FSM returns to RUN.
REQ-034 STALL_LIMIT=4, mem=1 for 6 cycles -> stall_timeout rises on the 4th stall edge and stays 1 after mem drops, until rst.
REQ-035 rst pulsed in the FLUSH_WAIT cycle -> next cycle state RUN, flush=0, stall=0, new_pc=0; with PIPE_CTRL_PERF_EN defined, both counters read 0.
